time_of_day_counter: RTL and testbench
======================================

// Module: time_of_day_counter
// PURPOSE
//  - Receiving end of the 1 Hz divider chain: consumes the free-running 1 Hz pulse and keeps time of day as BCD.
//  - Counts seconds, minutes and hours; supports manual time-set; feeds the seven-segment display decoders of the digital clock.
//  - The 1 Hz input comes from a ripple-clocked divider, so it is treated as asynchronous: synchronized, then edge-detected.
// PARAMETERS
//  - SYNC_STAGES  2  flip-flop stages on each async input (TICK_IN, INC_MIN, INC_HR); minimum 2
//  - HOURS_24     1  1 = 00..23 hour format; 0 = 12-hour format 12,01..11 with PM flag
// PORTS
//  - CLK_MHZ_50  in   1  system clock, 50 MHz; single clock domain
//  - Clear       in   1  reset, asynchronous, active-high
//  - TICK_IN     in   1  1 Hz pulse from divider chain; async; high for >= 2 CLK periods
//  - RUN         in   1  1 = timekeeping; 0 = set mode; sampled synchronously, slide switch
//  - INC_MIN     in   1  set-mode minute increment; async pushbutton, pre-debounced
//  - INC_HR      in   1  set-mode hour increment; async pushbutton, pre-debounced
//  - SEC_ONES    out  4  BCD seconds units
//  - SEC_TENS    out  4  BCD seconds tens
//  - MIN_ONES    out  4  BCD minutes units
//  - MIN_TENS    out  4  BCD minutes tens
//  - HR_ONES     out  4  BCD hours units
//  - HR_TENS     out  4  BCD hours tens
//  - PM          out  1  PM indicator; 12-hour mode only; constant 0 when HOURS_24=1
//  - SEC_PULSE   out  1  one-cycle strobe on every seconds advance
//  - DAY_PULSE   out  1  one-cycle strobe on wrap from last second of day to midnight
// BEHAVIOUR
//  - Reset (Clear=1, async): all outputs forced immediately, synchronizer flops cleared.
//    - Time = 00:00:00 (24h), or 12:00:00 with PM=0 (12h).
//    - SEC_PULSE=0, DAY_PULSE=0.
//  - Edge detect: a rising edge on the last sync stage of TICK_IN produces a tick, one cycle wide.
//    - Registered outputs change SYNC_STAGES+1 CLK cycles after the TICK_IN rising edge.
//    - A long TICK_IN high level produces exactly one tick.
//    - INC_MIN and INC_HR use the same sync + rising-edge scheme and have the same latency.
//  - RUN=1 (timekeeping):
//    - Each tick: seconds +1 BCD. 59->00 carries to minutes; minutes 59->00 carries to hours. Whole carry resolves in the same cycle.
//    - Hours (24h): 23->00.
//    - Hours (12h): 11->12 toggles PM; 12->01 leaves PM unchanged.
//    - SEC_PULSE is asserted in the update cycle.
//    - DAY_PULSE is asserted in the update cycle of the 23:59:59 -> 00:00:00 wrap (24h), or 11:59:59 PM -> 12:00:00 AM (12h).
//    - INC_MIN and INC_HR edges are ignored.
//  - RUN=0 (set mode):
//    - Ticks are ignored; seconds held at 00; SEC_PULSE and DAY_PULSE stay 0.
//    - INC_MIN edge: minutes +1 mod 60, no carry into hours.
//    - INC_HR edge: hours +1 with the same wrap and PM rule as timekeeping.
//    - INC_MIN and INC_HR edges in the same cycle: both fields update in that cycle.
//  - Transitions: the 1->0 RUN transition clears seconds to 00 on the next cycle. The 0->1 transition resumes counting from 00 at the next tick.
//  - RUN change in the same cycle as a tick: the new RUN value wins.
//  - Every BCD digit stays in 0..9 and tens digits stay in range at all times.
//    - No state is reachable outside 00..59 (sec/min) or the legal hour range.
//    - Illegal values produced by a fault are corrected at the next increment of that field (wrap to 0, or to 1 for 12h hours).
//  - Clear asserted mid-count or mid-set: immediate return to the reset state; pending edges are discarded.
// STRUCTURE
//  - Package clock_pkg: BCD digit typedef (4 bits), constants SEC_MAX=59, MIN_MAX=59, HR24_MAX=23, HR12_MAX=12, HR12_MIN=1.
//  - Sub-module bcd_mod_counter:
//    - Two-digit BCD counter with parameterized min/max, an inc enable, and a wrap/carry-out strobe.
//    - Instantiated three times (sec, min, hr); the hr instance uses the 12/24 bounds.
//  - In the top module: the synchronizer + edge-detect logic, the RUN mode control, the 12h PM toggle and the DAY_PULSE logic.
// TESTING
//  - Reset: assert Clear mid-count -> outputs read 00:00:00 without waiting for a CLK edge. With HOURS_24=0 -> 12:00:00, PM=0.
//  - Tick latency: single TICK_IN rising edge -> SEC_ONES=1 exactly 3 CLK cycles later (SYNC_STAGES=2). SEC_PULSE high for 1 cycle. TICK_IN held high 10 cycles -> still only +1.
//  - Carry chain: preset 23:59:59 via set mode + ticks, apply 1 tick -> 00:00:00 in a single cycle, DAY_PULSE=1 for 1 cycle.
//  - 12h wrap: at 11:59:59 PM=0, 1 tick -> 12:00:00 PM=1. At 12:59:59, 1 tick -> 01:00:00 with PM unchanged.
//  - Set mode: RUN=0 at 10:20:35 -> 10:20:00.
//    - 45 INC_MIN edges -> 10:05:00, hours unchanged.
//    - Ticks during set mode -> no change.
//    - INC_HR 14 times from 10 -> 00 (24h).
//  - Collisions: INC_MIN and INC_HR edges in the same cycle -> both fields +1. Tick in the same cycle as RUN 1->0 -> no advance, seconds cleared.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and field limits for the time-of-day counter.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MAX = 12;
    localparam int HR12_MIN = 1;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN_VAL..MAX_VAL with a same-cycle carry strobe.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59,
    parameter int RST_VAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t ones,
    output bcd_t tens,
    output logic carry
);

    localparam bcd_t       MIN_ONES = bcd_t'(MIN_VAL % 10);
    localparam bcd_t       MIN_TENS = bcd_t'(MIN_VAL / 10);
    localparam bcd_t       MAX_ONES = bcd_t'(MAX_VAL % 10);
    localparam bcd_t       MAX_TENS = bcd_t'(MAX_VAL / 10);
    localparam bcd_t       RST_ONES = bcd_t'(RST_VAL % 10);
    localparam bcd_t       RST_TENS = bcd_t'(RST_VAL / 10);
    localparam logic [7:0] MIN_BIN  = 8'(MIN_VAL);
    localparam logic [7:0] MAX_BIN  = 8'(MAX_VAL);

    logic [7:0] value;
    logic       at_max;
    logic       illegal;
    logic       below_min;
    bcd_t       ones_next;
    bcd_t       tens_next;

    assign value = ({4'd0, tens} * 8'd10) + {4'd0, ones};

    generate
        if (MIN_VAL > 0) begin : g_min_check
            assign below_min = (value < MIN_BIN);
        end else begin : g_no_min_check
            assign below_min = 1'b0;
        end
    endgenerate

    // Any out-of-range value folds back to the minimum on its next increment.
    always_comb begin
        at_max    = (ones == MAX_ONES) && (tens == MAX_TENS);
        illegal   = (ones > 4'd9) || (value > MAX_BIN) || below_min;
        ones_next = ones + 4'd1;
        tens_next = tens;
        if (at_max || illegal) begin
            ones_next = MIN_ONES;
            tens_next = MIN_TENS;
        end else if (ones == 4'd9) begin
            ones_next = 4'd0;
            tens_next = tens + 4'd1;
        end
    end

    assign carry = inc && at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones <= RST_ONES;
            tens <= RST_TENS;
        end else if (clr) begin
            ones <= MIN_ONES;
            tens <= MIN_TENS;
        end else if (inc) begin
            ones <= ones_next;
            tens <= tens_next;
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// BCD time-of-day keeper driven by an asynchronous 1 Hz tick, with a manual set mode.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOURS_24    = 1
) (
    input  logic CLK_MHZ_50,
    input  logic Clear,
    input  logic TICK_IN,
    input  logic RUN,
    input  logic INC_MIN,
    input  logic INC_HR,
    output bcd_t SEC_ONES,
    output bcd_t SEC_TENS,
    output bcd_t MIN_ONES,
    output bcd_t MIN_TENS,
    output bcd_t HR_ONES,
    output bcd_t HR_TENS,
    output logic PM,
    output logic SEC_PULSE,
    output logic DAY_PULSE
);

    localparam int   MSB    = SYNC_STAGES - 1;
    localparam logic IS_12H = (HOURS_24 == 0);
    localparam int   HR_MIN = IS_12H ? HR12_MIN : 0;
    localparam int   HR_MAX = IS_12H ? HR12_MAX : HR24_MAX;
    localparam int   HR_RST = IS_12H ? HR12_MAX : 0;

    logic [MSB:0] tick_sync;
    logic [MSB:0] min_sync;
    logic [MSB:0] hr_sync;
    logic [2:0]   last;
    logic         tick_edge;
    logic         min_edge;
    logic         hr_edge;
    logic         sec_inc;
    logic         min_inc;
    logic         hr_inc;
    logic         sec_carry;
    logic         min_carry;
    logic         hr_carry;
    logic         hr_is_11;
    logic         pm;
    logic         pm_toggle;
    logic         day_wrap;

    always_ff @(posedge CLK_MHZ_50 or posedge Clear) begin
        if (Clear) begin
            tick_sync <= '0;
            min_sync  <= '0;
            hr_sync   <= '0;
            last      <= '0;
        end else begin
            tick_sync <= {tick_sync[MSB-1:0], TICK_IN};
            min_sync  <= {min_sync[MSB-1:0], INC_MIN};
            hr_sync   <= {hr_sync[MSB-1:0], INC_HR};
            last      <= {hr_sync[MSB], min_sync[MSB], tick_sync[MSB]};
        end
    end

    assign tick_edge = tick_sync[MSB] & ~last[0];
    assign min_edge  = min_sync[MSB] & ~last[1];
    assign hr_edge   = hr_sync[MSB] & ~last[2];

    // RUN is used unsynchronized so a RUN change always overrides a coincident tick.
    assign sec_inc = RUN & tick_edge;
    assign min_inc = RUN ? sec_carry : min_edge;
    assign hr_inc  = RUN ? min_carry : hr_edge;

    bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(SEC_MAX), .RST_VAL(0)) u_sec (
        .clk   (CLK_MHZ_50),
        .rst   (Clear),
        .clr   (~RUN),
        .inc   (sec_inc),
        .ones  (SEC_ONES),
        .tens  (SEC_TENS),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(MIN_MAX), .RST_VAL(0)) u_min (
        .clk   (CLK_MHZ_50),
        .rst   (Clear),
        .clr   (1'b0),
        .inc   (min_inc),
        .ones  (MIN_ONES),
        .tens  (MIN_TENS),
        .carry (min_carry)
    );

    bcd_mod_counter #(.MIN_VAL(HR_MIN), .MAX_VAL(HR_MAX), .RST_VAL(HR_RST)) u_hr (
        .clk   (CLK_MHZ_50),
        .rst   (Clear),
        .clr   (1'b0),
        .inc   (hr_inc),
        .ones  (HR_ONES),
        .tens  (HR_TENS),
        .carry (hr_carry)
    );

    // 12h: the 11 -> 12 step flips AM/PM; leaving 11 PM is the midnight wrap.
    assign hr_is_11  = (HR_TENS == 4'd1) && (HR_ONES == 4'd1);
    assign pm_toggle = IS_12H && hr_inc && hr_is_11;
    assign day_wrap  = RUN && (IS_12H ? (hr_inc && hr_is_11 && pm) : hr_carry);

    always_ff @(posedge CLK_MHZ_50 or posedge Clear) begin
        if (Clear) begin
            pm        <= 1'b0;
            SEC_PULSE <= 1'b0;
            DAY_PULSE <= 1'b0;
        end else begin
            pm        <= pm ^ pm_toggle;
            SEC_PULSE <= sec_inc;
            DAY_PULSE <= day_wrap;
        end
    end

    assign PM = IS_12H && pm;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench: a 24h and a 12h instance share stimulus; 12h expectations are derived from the 24h time.
module tb_time_of_day_counter;
    import clock_pkg::*;

    logic clk = 1'b0;
    logic clear;
    logic tick_in;
    logic run;
    logic inc_min;
    logic inc_hr;

    bcd_t a_so, a_st, a_mo, a_mt, a_ho, a_ht;
    bcd_t b_so, b_st, b_mo, b_mt, b_ho, b_ht;
    logic a_pm, a_sp, a_dp;
    logic b_pm, b_sp, b_dp;

    int n_asserts = 0;
    int n_fail    = 0;

    always #10 clk = ~clk;

    time_of_day_counter #(.SYNC_STAGES(2), .HOURS_24(1)) dut24 (
        .CLK_MHZ_50 (clk),     .Clear    (clear),  .TICK_IN   (tick_in),
        .RUN        (run),     .INC_MIN  (inc_min), .INC_HR   (inc_hr),
        .SEC_ONES   (a_so),    .SEC_TENS (a_st),   .MIN_ONES  (a_mo),
        .MIN_TENS   (a_mt),    .HR_ONES  (a_ho),   .HR_TENS   (a_ht),
        .PM         (a_pm),    .SEC_PULSE(a_sp),   .DAY_PULSE (a_dp)
    );

    time_of_day_counter #(.SYNC_STAGES(2), .HOURS_24(0)) dut12 (
        .CLK_MHZ_50 (clk),     .Clear    (clear),  .TICK_IN   (tick_in),
        .RUN        (run),     .INC_MIN  (inc_min), .INC_HR   (inc_hr),
        .SEC_ONES   (b_so),    .SEC_TENS (b_st),   .MIN_ONES  (b_mo),
        .MIN_TENS   (b_mt),    .HR_ONES  (b_ho),   .HR_TENS   (b_ht),
        .PM         (b_pm),    .SEC_PULSE(b_sp),   .DAY_PULSE (b_dp)
    );

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        chk(tag, {7'd0, got}, {7'd0, exp});
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        int h12;
        h12 = ((h % 12) == 0) ? 12 : (h % 12);
        chk({tag, " 24h sec"}, {a_st, a_so}, bcd2(s));
        chk({tag, " 24h min"}, {a_mt, a_mo}, bcd2(m));
        chk({tag, " 24h hr"},  {a_ht, a_ho}, bcd2(h));
        chk_bit({tag, " 24h pm"}, a_pm, 1'b0);
        chk({tag, " 12h sec"}, {b_st, b_so}, bcd2(s));
        chk({tag, " 12h min"}, {b_mt, b_mo}, bcd2(m));
        chk({tag, " 12h hr"},  {b_ht, b_ho}, bcd2(h12));
        chk_bit({tag, " 12h pm"}, b_pm, (h >= 12));
    endtask

    // sel: 0 = tick, 1 = min, 2 = hr, 3 = min and hr together
    task automatic pulse(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_in = (sel == 0);
            inc_min = (sel == 1) || (sel == 3);
            inc_hr  = (sel == 2) || (sel == 3);
            repeat (3) @(negedge clk);
            tick_in = 1'b0;
            inc_min = 1'b0;
            inc_hr  = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic tick_watch(input string tag, input logic exp_day);
        @(negedge clk);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        chk_bit({tag, " 24h sec_pulse early"}, a_sp, 1'b0);
        chk_bit({tag, " 24h day_pulse early"}, a_dp, 1'b0);
        @(negedge clk);
        chk_bit({tag, " 24h sec_pulse"}, a_sp, 1'b1);
        chk_bit({tag, " 12h sec_pulse"}, b_sp, 1'b1);
        chk_bit({tag, " 24h day_pulse"}, a_dp, exp_day);
        chk_bit({tag, " 12h day_pulse"}, b_dp, exp_day);
        @(negedge clk);
        chk_bit({tag, " 24h sec_pulse after"}, a_sp, 1'b0);
        chk_bit({tag, " 24h day_pulse after"}, a_dp, 1'b0);
        chk_bit({tag, " 12h day_pulse after"}, b_dp, 1'b0);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clear   = 1'b1;
        tick_in = 1'b0;
        run     = 1'b1;
        inc_min = 1'b0;
        inc_hr  = 1'b0;
        repeat (2) @(negedge clk);
        chk_time("reset", 0, 0, 0);
        chk_bit("reset sec_pulse", a_sp, 1'b0);
        chk_bit("reset day_pulse", a_dp, 1'b0);
        @(negedge clk);
        clear = 1'b0;

        // Tick latency and long-high tick
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        chk("lat c1 sec", {a_st, a_so}, 8'h00);
        @(negedge clk);
        chk("lat c2 sec", {a_st, a_so}, 8'h00);
        chk_bit("lat c2 sec_pulse", a_sp, 1'b0);
        @(negedge clk);
        chk("lat c3 24h sec", {a_st, a_so}, 8'h01);
        chk("lat c3 12h sec", {b_st, b_so}, 8'h01);
        chk_bit("lat c3 sec_pulse", a_sp, 1'b1);
        @(negedge clk);
        chk_bit("lat c4 sec_pulse", a_sp, 1'b0);
        repeat (6) @(negedge clk);
        chk_bit("long tick no repulse", a_sp, 1'b0);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_time("long tick", 0, 0, 1);

        // Asynchronous clear between clock edges
        pulse(0, 1);
        chk_time("pre clear", 0, 0, 2);
        @(negedge clk);
        #3 clear = 1'b1;
        #1 chk_time("async clear", 0, 0, 0);
        #2 clear = 1'b0;

        // Set mode to 10:20, then run to 10:20:35
        @(negedge clk);
        run = 1'b0;
        pulse(2, 10);
        chk_time("set hr 10", 10, 0, 0);
        pulse(1, 20);
        @(negedge clk);
        run = 1'b1;
        pulse(0, 35);
        chk_time("run 10:20:35", 10, 20, 35);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk_time("run 1->0 clears sec", 10, 20, 0);
        pulse(1, 45);
        chk_time("45 inc_min", 10, 5, 0);
        pulse(0, 3);
        chk_time("ticks in set mode", 10, 5, 0);
        chk_bit("set mode sec_pulse", a_sp, 1'b0);
        pulse(2, 14);
        chk_time("14 inc_hr", 0, 5, 0);
        chk_bit("set mode day_pulse", a_dp, 1'b0);
        pulse(3, 1);
        chk_time("min+hr collision", 1, 6, 0);

        // 11:59:59 -> 12:00:00 (noon)
        pulse(2, 10);
        pulse(1, 53);
        @(negedge clk);
        run = 1'b1;
        pulse(0, 59);
        chk_time("at 11:59:59", 11, 59, 59);
        tick_watch("noon", 1'b0);
        chk_time("noon", 12, 0, 0);

        // 12:59:59 -> 13:00:00 (12h: 01 PM)
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk_time("noon set mode", 12, 0, 0);
        pulse(1, 59);
        @(negedge clk);
        run = 1'b1;
        pulse(0, 59);
        chk_time("at 12:59:59", 12, 59, 59);
        tick_watch("one pm", 1'b0);
        chk_time("one pm", 13, 0, 0);

        // Midnight wrap
        @(negedge clk);
        run = 1'b0;
        pulse(2, 10);
        pulse(1, 59);
        @(negedge clk);
        run = 1'b1;
        pulse(0, 59);
        chk_time("at 23:59:59", 23, 59, 59);
        tick_watch("midnight", 1'b1);
        chk_time("midnight", 0, 0, 0);

        // Tick coinciding with RUN 1->0
        pulse(0, 1);
        chk_time("pre collision", 0, 0, 1);
        @(negedge clk);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk_bit("run/tick collision sec_pulse", a_sp, 1'b0);
        chk_time("run/tick collision", 0, 0, 0);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_time("after collision", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
